// File: rtl/led_seq_pkg.sv
// Shared types, widths and pattern helpers for the LED walking-one checker.
package led_seq_pkg;

    localparam int DATA_W  = 8;
    localparam int IDX_W   = 4;
    localparam int SEQ_LEN = DATA_W;
    localparam int MATCH_W = 16;
    localparam int MISS_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HUNT   = 3'd1,
        ST_TRACK  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_LOST   = 3'd4
    } state_t;

    function automatic logic [DATA_W-1:0] exp_pattern(input logic [IDX_W-1:0] idx);
        return DATA_W'(1) << idx;
    endfunction

    // Returns {valid, index}; valid only when exactly one bit of vec is set.
    function automatic logic [IDX_W:0] onehot_index(input logic [DATA_W-1:0] vec);
        logic [IDX_W-1:0] index;
        int unsigned      ones;
        index = '0;
        ones  = 0;
        for (int i = 0; i < DATA_W; i++) begin
            if (vec[i]) begin
                ones++;
                index = IDX_W'(i);
            end
        end
        return {(ones == 1), index};
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(SEQ_LEN - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_checker.sv
// Locks onto the walking-one LED stream, flywheels through isolated misses
// and reports match/miss statistics plus a sticky loss-of-lock flag.
//
// state  | meaning
// IDLE   | checker disabled
// HUNT   | searching for any single-hot sample
// TRACK  | consecutive matches accumulating towards lock
// LOCKED | following the sequence, counting matches and misses
// LOST   | one-cycle loss-of-lock marker, then back to HUNT
module led_seq_checker
    import led_seq_pkg::*;
#(
    parameter int DATA_W   = led_seq_pkg::DATA_W,
    parameter int IDX_W    = led_seq_pkg::IDX_W,
    parameter int LOCK_CNT = 4,
    parameter int MISS_MAX = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_valid,
    input  logic [DATA_W-1:0]   i_led,
    output logic [2:0]          o_state,
    output logic                o_locked,
    output logic                o_err,
    output logic [IDX_W-1:0]    o_idx,
    output logic [MATCH_W-1:0]  o_match_cnt,
    output logic [MISS_W-1:0]   o_miss_cnt
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MRUN_W = $clog2(MISS_MAX + 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [RUN_W-1:0]   run;
    logic [MRUN_W-1:0]  miss_run;
    logic               err;

    logic               hit;
    logic [IDX_W:0]     hunt_oh;
    logic [RUN_W-1:0]   run_inc;
    logic [MRUN_W-1:0]  miss_run_inc;
    logic               cnt_clr;
    logic               locked_sample;

    assign hit           = (i_led == exp_pattern(idx));
    assign hunt_oh       = onehot_index(i_led);
    assign run_inc       = run + 1'b1;
    assign miss_run_inc  = miss_run + 1'b1;
    assign cnt_clr       = i_en && (state == ST_IDLE);
    assign locked_sample = i_en && i_valid && (state == ST_LOCKED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            run      <= '0;
            miss_run <= '0;
            err      <= 1'b0;
        end else if (!i_en) begin
            state    <= ST_IDLE;
            idx      <= '0;
            run      <= '0;
            miss_run <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_HUNT;
                    err   <= 1'b0;
                end
                ST_HUNT: begin
                    if (i_valid && hunt_oh[IDX_W]) begin
                        idx      <= next_idx(hunt_oh[IDX_W-1:0]);
                        run      <= RUN_W'(1);
                        miss_run <= '0;
                        state    <= (LOCK_CNT == 1) ? ST_LOCKED : ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (i_valid) begin
                        if (hit) begin
                            idx <= next_idx(idx);
                            run <= run_inc;
                            if (run_inc == RUN_W'(LOCK_CNT)) begin
                                state    <= ST_LOCKED;
                                miss_run <= '0;
                            end
                        end else begin
                            // Mismatching sample is dropped, not reused as a hunt candidate.
                            run   <= '0;
                            state <= ST_HUNT;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (i_valid) begin
                        idx <= next_idx(idx);
                        if (hit) begin
                            miss_run <= '0;
                        end else begin
                            miss_run <= miss_run_inc;
                            if (miss_run_inc == MRUN_W'(MISS_MAX)) begin
                                state <= ST_LOST;
                                err   <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOST: begin
                    state    <= ST_HUNT;
                    run      <= '0;
                    miss_run <= '0;
                    err      <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(MATCH_W)) u_match_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (cnt_clr),
        .inc     (locked_sample && hit),
        .cnt     (o_match_cnt)
    );

    sat_counter #(.W(MISS_W)) u_miss_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (cnt_clr),
        .inc     (locked_sample && !hit),
        .cnt     (o_miss_cnt)
    );

    assign o_state  = state;
    assign o_locked = (state == ST_LOCKED);
    assign o_err    = err;
    assign o_idx    = idx;

endmodule
